alu_seq_wide: RTL and testbench

- Multi-cycle wide-word ALU front end that drives one alu8 instance byte-serially, LSB byte first, chaining carry through a register.
- Accepts one command on a valid/ready request channel and returns result and flags on a valid/ready response channel.
- Sits between an instruction sequencer and the 8-bit datapath, giving 8*NBYTES-bit add/sub/logic without widening the adder.

---
 rtl/alu_seq_wide_if.sv | 21 ++
 rtl/alu_seq_wide.sv | 112 +++++++++++
 tb/tb_alu_seq_wide.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_wide_if.sv
// alu_seq_wide_if: command and response channels of the byte-serial wide ALU
interface alu_seq_wide_if #(parameter int NBYTES = 2);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [8*NBYTES-1:0]   cmd_a;
    logic [8*NBYTES-1:0]   cmd_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [8*NBYTES-1:0]   rsp_res;
    logic [3:0]            rsp_flags;
    logic                  c_flag;
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_res, rsp_flags, c_flag
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_res, rsp_flags, c_flag
    );
endinterface

// File: rtl/alu_seq_wide.sv
// alu_seq_wide: wide-word ALU built from one 8-bit ALU run LSB byte first
module alu8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] op,
    output logic [7:0] y,
    output logic       c_out
);
    logic [7:0] bx;
    logic [8:0] s;
    // op = {k, i, j, c_in}: k selects the adder, j inverts b (or selects xor), i selects or
    always_comb begin
        bx    = op[1] ? ~b : b;
        s     = {1'b0, a} + {1'b0, bx} + {8'd0, op[0]};
        y     = op[3] ? s[7:0] : op[2] ? (a | b) : op[1] ? (a ^ b) : (a & b);
        c_out = op[3] & s[8];
    end
endmodule

module alu_seq_wide #(parameter int NBYTES = 2) (
    input  logic         clk,
    input  logic         rst,
    alu_seq_wide_if.slave bus
);
    localparam int W = 8 * NBYTES;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic           cy_q, cy_d;
    logic [3:0]     flags_q, flags_d;
    logic           cf_q, cf_d;
    logic           arith, sub, last, v;
    logic [3:0]     alu_op;
    logic [7:0]     a_byte, b_byte, y;
    logic           co;
    logic [W-1:0]   alu_w;
    alu8 u_alu (.a(a_byte), .b(b_byte), .op(alu_op), .y(y), .c_out(co));
    // byte slicing, full-word result assembly and next-state/output decode
    always_comb begin
        arith   = (op_q[2] == 1'b0) || (op_q == 3'd7);
        sub     = (op_q == 3'd1) || (op_q == 3'd3) || (op_q == 3'd7);
        alu_op  = {arith, arith | (op_q == 3'd5), sub | (op_q == 3'd6), arith & cy_q};
        a_byte  = a_q[8*idx_q +: 8];
        b_byte  = b_q[8*idx_q +: 8];
        alu_w   = res_q;
        alu_w[8*idx_q +: 8] = y;
        last    = idx_q == 3'(NBYTES - 1);
        // overflow from the top byte: operands agree in sign, result differs
        v       = arith & (a_q[W-1] == (b_q[W-1] ^ sub)) & (alu_w[W-1] != a_q[W-1]);
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cy_d    = cy_q;
        flags_d = flags_q;
        cf_d    = cf_q;
        if (state_q == IDLE && bus.cmd_valid) begin
            state_d = EXEC;
            idx_d   = '0;
            op_d    = bus.cmd_op;
            a_d     = bus.cmd_a;
            b_d     = bus.cmd_b;
            cy_d    = (bus.cmd_op == 3'd2 || bus.cmd_op == 3'd3) ? cf_q
                    : (bus.cmd_op == 3'd1 || bus.cmd_op == 3'd7);
        end else if (state_q == EXEC) begin
            res_d = alu_w;
            cy_d  = co;
            idx_d = idx_q + 3'd1;
            if (last) begin
                state_d = RESP;
                res_d   = (op_q == 3'd7) ? a_q : alu_w;
                flags_d = {arith & co, alu_w == '0, v, alu_w[W-1]};
                cf_d    = arith ? co : cf_q;
            end
        end else if (state_q == RESP && bus.rsp_ready) begin
            state_d = IDLE;
        end
        bus.cmd_ready = state_q == IDLE;
        bus.rsp_valid = state_q == RESP;
        bus.rsp_res   = res_q;
        bus.rsp_flags = flags_q;
        bus.c_flag    = cf_q;
    end
    // state and datapath registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
            flags_q <= '0;
            cf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
            flags_q <= flags_d;
            cf_q    <= cf_d;
        end
    end
endmodule

// File: tb/tb_alu_seq_wide.sv
// tb_alu_seq_wide: directed vectors with a response scoreboard
module tb_alu_seq_wide;
    localparam int NB = 2;
    localparam int W  = 8 * NB;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [W+3:0] exp_q[$];
    alu_seq_wide_if #(.NBYTES(NB)) bus ();
    alu_seq_wide #(.NBYTES(NB)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor: compare every accepted response with the oldest expectation
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(bus.rsp_res), 32'hdead);
            end else begin
                logic [W+3:0] e;
                e = exp_q.pop_front();
                chk("rsp_res", 32'(bus.rsp_res), 32'(e[W+3:4]));
                chk("rsp_flags", 32'(bus.rsp_flags), 32'(e[3:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic [3:0] ef, input logic ecf);
        int n;
        bus.cmd_op = op;
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_timeout", 32'(n < 50), 32'd1);
        exp_q.push_back({er, ef});
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a = ~a;
        bus.cmd_b = ~b;
        n = 1;
        while (!bus.rsp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_latency_edges", 32'(n), 32'(NB + 1));
        n = 0;
        while (bus.rsp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("c_flag", 32'(bus.c_flag), 32'(ecf));
        chk("cmd_ready_after_rsp", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_res", 32'(bus.rsp_res), 32'd0);
        chk("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
        chk("rst_c_flag", 32'(bus.c_flag), 32'd0);
        rst = 1'b0;
        issue(3'd0, 16'h00FF, 16'h0001, 16'h0100, 4'b0000, 1'b0);
        issue(3'd1, 16'h1234, 16'h1234, 16'h0000, 4'b1100, 1'b1);
        issue(3'd7, 16'h0001, 16'h0002, 16'h0001, 4'b0001, 1'b0);
        issue(3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011, 1'b0);
        issue(3'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b1010, 1'b1);
        issue(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100, 1'b1);
        issue(3'd2, 16'h0000, 16'h0000, 16'h0001, 4'b0000, 1'b0);
        issue(3'd3, 16'h0005, 16'h0003, 16'h0001, 4'b1000, 1'b1);
        issue(3'd6, 16'hF0F0, 16'hFFFF, 16'h0F0F, 4'b0000, 1'b1);
        // reset during the second EXEC cycle aborts the add
        bus.cmd_op = 3'd0;
        bus.cmd_a = 16'h1111;
        bus.cmd_b = 16'h2222;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("abort_c_flag", 32'(bus.c_flag), 32'd0);
        chk("abort_rsp_res", 32'(bus.rsp_res), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        issue(3'd4, 16'hFF00, 16'h0FF0, 16'h0F00, 4'b0000, 1'b0);
        // backpressure with a second command pending
        bus.rsp_ready = 1'b0;
        bus.cmd_op = 3'd0;
        bus.cmd_a = 16'h0102;
        bus.cmd_b = 16'h0304;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back({16'h0406, 4'b0000});
        bus.cmd_op = 3'd5;
        bus.cmd_a = 16'h00F0;
        bus.cmd_b = 16'h0F00;
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_rsp_timeout", 32'(n < 50), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_res", 32'(bus.rsp_res), 32'h0406);
            chk("bp_rsp_flags", 32'(bus.rsp_flags), 32'd0);
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("bp_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        exp_q.push_back({16'h0FF0, 4'b0000});
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        chk("bp_next_accepted", 32'(bus.cmd_ready), 32'd0);
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_next_done", 32'(n < 50), 32'd1);
        chk("bp_c_flag", 32'(bus.c_flag), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
